// File: rtl/cpu6_bench_pkg.sv
// cpu6_bench_pkg: shared state/end-cause types and CPU6 bus defaults for the bench controller
package cpu6_bench_pkg;
    localparam int CPU6_ADDR_WIDTH = 16;
    localparam int CPU6_DATA_WIDTH = 8;
    typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
    typedef enum logic [1:0] {NONE, HALT, STALL, TIMEOUT} end_e;
endpackage

// File: rtl/cpu6_trace_ring.sv
// cpu6_trace_ring: DEPTH-entry ring of {address, data} samples with newest-relative indexed read
// Ports:
//   clock, reset     - clock and synchronous active-low reset (clears ring and pointer)
//   we_i             - write one entry this cycle
//   addr_i, data_i   - sample written at the write pointer
//   idx_i            - read index, 0 is the newest entry
//   addr_o, data_o   - combinational read of entry (wptr-1-idx) mod DEPTH
module cpu6_trace_ring #(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic [IW-1:0] idx_i,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);
    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [IW-1:0]    wptr_q;
    logic [IW-1:0]    rptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[wptr_q] <= {addr_i, data_i};
            // DEPTH is a power of two, so the pointer wraps naturally
            wptr_q        <= wptr_q + IW'(1);
        end
    end

    assign rptr             = wptr_q - IW'(1) - idx_i;
    assign {addr_o, data_o} = mem_q[rptr];
endmodule

// File: rtl/cpu6_bench_controller.sv
// cpu6_bench_controller: CPU6 bench run controller - reset sequencing, run-cycle count, halt/stall/timeout detection
// Ports:
//   clock, reset             - clock and synchronous active-low reset
//   address_bus, data_bus    - observed CPU6 buses (data only feeds the trace)
//   cpu_reset                - active-high CPU reset; held for RESET_CYCLES, reasserted in DONE to freeze the CPU
//   running, done            - in RUN / run has ended (sticky)
//   pass, timeout, stalled   - end cause flags (sticky, only the highest-priority cause is set)
//   cycle_count              - RUN cycles elapsed, saturating, includes the terminating cycle
//   trace_idx/addr/data      - trace ring read port
// Optional feature: define CPU6_BENCH_TRACE_EN to build the trace ring; otherwise trace outputs are tied to 0.
module cpu6_bench_controller
    import cpu6_bench_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = CPU6_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = CPU6_DATA_WIDTH,
    parameter int                    CNT_WIDTH      = 32,
    parameter int                    RESET_CYCLES   = 4,
    parameter int                    TIMEOUT_CYCLES = 3000,
    parameter int                    STALL_CYCLES   = 16,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = ADDR_WIDTH'(16'hFFFF),
    parameter int                    TRACE_DEPTH    = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          address_bus,
    input  logic [DATA_WIDTH-1:0]          data_bus,
    output logic                           cpu_reset,
    output logic                           running,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic                           stalled,
    output logic [CNT_WIDTH-1:0]           cycle_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [ADDR_WIDTH-1:0]          trace_addr,
    output logic [DATA_WIDTH-1:0]          trace_data
);
    localparam logic [7:0]           HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] STALL_LIM = CNT_WIDTH'(STALL_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TO_LIM    = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_e                state_q;
    logic [7:0]            hold_q;
    logic                  cpu_reset_q, running_q, done_q, pass_q, timeout_q, stalled_q;
    logic [CNT_WIDTH-1:0]  cycle_q, cycle_d, stall_q, stall_d;
    logic [ADDR_WIDTH-1:0] last_q;
    logic                  same;
    end_e                  cause_d;

    always_comb begin
        same    = address_bus == last_q;
        stall_d = !same ? ONE : (stall_q == STALL_LIM) ? stall_q : stall_q + ONE;
        cycle_d = &cycle_q ? cycle_q : cycle_q + ONE;
        // priority: halt, then stall, then timeout
        cause_d = (address_bus == HALT_ADDR) ? HALT
                : (STALL_CYCLES != 0 && same && stall_q + ONE == STALL_LIM) ? STALL
                : (cycle_q + ONE == TO_LIM) ? TIMEOUT
                : NONE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= HOLD;
            hold_q      <= '0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stalled_q   <= 1'b0;
            cycle_q     <= '0;
            stall_q     <= '0;
            last_q      <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    hold_q <= hold_q + 8'd1;
                    if (hold_q == HOLD_LAST) begin
                        state_q     <= RUN;
                        cpu_reset_q <= 1'b0;
                        running_q   <= 1'b1;
                    end
                end
                RUN: begin
                    cycle_q <= cycle_d;
                    last_q  <= address_bus;
                    stall_q <= stall_d;
                    if (cause_d != NONE) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        running_q   <= 1'b0;
                        cpu_reset_q <= 1'b1;
                        pass_q      <= cause_d == HALT;
                        stalled_q   <= cause_d == STALL;
                        timeout_q   <= cause_d == TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign stalled     = stalled_q;
    assign cycle_count = cycle_q;

`ifdef CPU6_BENCH_TRACE_EN
    cpu6_trace_ring #(
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH),
        .DEPTH (TRACE_DEPTH)
    ) u_ring (
        .clock  (clock),
        .reset  (reset),
        .we_i   (state_q == RUN),
        .addr_i (address_bus),
        .data_i (data_bus),
        .idx_i  (trace_idx),
        .addr_o (trace_addr),
        .data_o (trace_data)
    );
`else
    logic unused_trace;
    assign unused_trace = ^{trace_idx, data_bus};
    assign trace_addr   = '0;
    assign trace_data   = '0;
`endif
endmodule

// File: tb/tb_cpu6_bench_controller.sv
// tb_cpu6_bench_controller: randomized self-checking bench for cpu6_bench_controller against a run-level model
module tb_cpu6_bench_controller;
    localparam int RC = 4;
    localparam int SA = 16, TA = 3000, SB = 0, TB = 40;
    localparam logic [15:0] HALT_A = 16'h0010;
    localparam logic [37:0] RESET_VEC = {32'd0, 6'b001000};

    logic        clock, reset;
    logic [15:0] address_bus;
    logic [7:0]  data_bus;
    logic [2:0]  trace_idx;
    logic        cpu_reset_a, running_a, done_a, pass_a, timeout_a, stalled_a;
    logic        cpu_reset_b, running_b, done_b, pass_b, timeout_b, stalled_b;
    logic [31:0] cc_a, cc_b;
    logic [15:0] ta_a, ta_b;
    logic [7:0]  td_a, td_b;
    logic [37:0] obs_a, obs_b;

    int          vectors = 0;
    int          errors = 0;
    logic [15:0] q[$];
    logic [7:0]  dq[$];

    cpu6_bench_controller #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TA), .STALL_CYCLES(SA),
                            .HALT_ADDR(HALT_A), .TRACE_DEPTH(8)) dut_a (
        .clock(clock), .reset(reset), .address_bus(address_bus), .data_bus(data_bus),
        .cpu_reset(cpu_reset_a), .running(running_a), .done(done_a), .pass(pass_a),
        .timeout(timeout_a), .stalled(stalled_a), .cycle_count(cc_a),
        .trace_idx(trace_idx), .trace_addr(ta_a), .trace_data(td_a));

    cpu6_bench_controller #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TB), .STALL_CYCLES(SB),
                            .HALT_ADDR(HALT_A), .TRACE_DEPTH(8)) dut_b (
        .clock(clock), .reset(reset), .address_bus(address_bus), .data_bus(data_bus),
        .cpu_reset(cpu_reset_b), .running(running_b), .done(done_b), .pass(pass_b),
        .timeout(timeout_b), .stalled(stalled_b), .cycle_count(cc_b),
        .trace_idx(trace_idx), .trace_addr(ta_b), .trace_data(td_b));

    assign obs_a = {cc_a, done_a, running_a, cpu_reset_a, pass_a, stalled_a, timeout_a};
    assign obs_b = {cc_b, done_b, running_b, cpu_reset_b, pass_b, stalled_b, timeout_b};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Run-level model: scans the RUN-cycle address list and returns the index of the
    // terminating cycle and its cause (1 halt, 2 stall, 3 timeout).
    function automatic void predict(input logic [15:0] a[$], input int s, input int t,
                                    output int e, output int c);
        int          run;
        logic [15:0] prev;
        run = 0; prev = 16'h0; e = -1; c = 0;
        foreach (a[k]) begin
            bit same;
            same = a[k] == prev;
            run  = (k > 0 && same) ? run + 1 : 1;
            if (a[k] == HALT_A) c = 1;
            else if (s != 0 && same && run == s) c = 2;
            else if (k + 1 == t) c = 3;
            if (c != 0) begin
                e = k;
                return;
            end
            prev = a[k];
        end
    endfunction

    // Expected {cycle_count, done, running, cpu_reset, pass, stalled, timeout} after RUN step k.
    function automatic logic [37:0] exp_vec(input int e, input int c, input int k);
        bit d;
        d = k >= e;
        return {32'(d ? e + 1 : k + 1), d, !d, d, d && c == 1, d && c == 2, d && c == 3};
    endfunction

    task automatic start_run();
        reset = 1'b0;
        dq.delete();
        repeat (3) begin
            address_bus = 16'($urandom);
            @(posedge clock); #1;
        end
        reset = 1'b1;
        repeat (RC) begin
            address_bus = 16'($urandom);
            @(posedge clock); #1;
        end
    endtask

    task automatic step(input logic [15:0] a);
        address_bus = a;
        data_bus    = 8'($urandom);
        dq.push_back(data_bus);
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        int na, nb;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        vectors += 2;
        if (obs_a !== RESET_VEC) begin errors++; $display("FAIL reset_a got %h want %h", obs_a, RESET_VEC); end
        if (obs_b !== RESET_VEC) begin errors++; $display("FAIL reset_b got %h want %h", obs_b, RESET_VEC); end
        reset = 1'b1;
        na = 0; nb = 0;
        for (int n = 1; n <= 20 && (na == 0 || nb == 0); n++) begin
            @(posedge clock); #1;
            if (na == 0 && !cpu_reset_a) na = n;
            if (nb == 0 && !cpu_reset_b) nb = n;
        end
        vectors += 4;
        if (na != RC) begin errors++; $display("FAIL hold_len_a got %0d want %0d", na, RC); end
        if (nb != RC) begin errors++; $display("FAIL hold_len_b got %0d want %0d", nb, RC); end
        if (obs_a !== {32'd0, 6'b010000}) begin errors++; $display("FAIL run_entry_a got %h want %h", obs_a, {32'd0, 6'b010000}); end
        if (obs_b !== {32'd0, 6'b010000}) begin errors++; $display("FAIL run_entry_b got %h want %h", obs_b, {32'd0, 6'b010000}); end
    endtask

    task automatic test_halt();
        int ea, ca, eb, cb;
        q.delete();
        for (int k = 0; k < 3004; k++) q.push_back(16'(k));
        predict(q, SA, TA, ea, ca);
        predict(q, SB, TB, eb, cb);
        start_run();
        for (int k = 0; k <= (ea > eb ? ea : eb) + 3; k++) begin
            step(q[k]);
            vectors += 2;
            if (obs_a !== exp_vec(ea, ca, k)) begin errors++; $display("FAIL halt_a k=%0d got %h want %h", k, obs_a, exp_vec(ea, ca, k)); end
            if (obs_b !== exp_vec(eb, cb, k)) begin errors++; $display("FAIL halt_b k=%0d got %h want %h", k, obs_b, exp_vec(eb, cb, k)); end
        end
    endtask

    task automatic test_stall();
        int ea, ca, eb, cb;
        q.delete();
        for (int k = 0; k < 3004; k++) q.push_back(16'h1234);
        predict(q, SA, TA, ea, ca);
        predict(q, SB, TB, eb, cb);
        start_run();
        for (int k = 0; k <= (ea > eb ? ea : eb) + 3; k++) begin
            step(q[k]);
            vectors += 2;
            if (obs_a !== exp_vec(ea, ca, k)) begin errors++; $display("FAIL stall_a k=%0d got %h want %h", k, obs_a, exp_vec(ea, ca, k)); end
            if (obs_b !== exp_vec(eb, cb, k)) begin errors++; $display("FAIL stall_b k=%0d got %h want %h", k, obs_b, exp_vec(eb, cb, k)); end
        end
    endtask

    task automatic test_timeout();
        int ea, ca, eb, cb;
        q.delete();
        for (int k = 0; k < 3004; k++) q.push_back(16'h0100 + 16'(k));
        predict(q, SA, TA, ea, ca);
        predict(q, SB, TB, eb, cb);
        start_run();
        for (int k = 0; k <= (ea > eb ? ea : eb) + 3; k++) begin
            step(q[k]);
            vectors += 2;
            if (obs_a !== exp_vec(ea, ca, k)) begin errors++; $display("FAIL timeout_a k=%0d got %h want %h", k, obs_a, exp_vec(ea, ca, k)); end
            if (obs_b !== exp_vec(eb, cb, k)) begin errors++; $display("FAIL timeout_b k=%0d got %h want %h", k, obs_b, exp_vec(eb, cb, k)); end
        end
    endtask

    // Halt on the cycle dut_b would time out, then halt on the very first RUN cycle.
    task automatic test_priority();
        int ea, ca, eb, cb;
        for (int r = 0; r < 2; r++) begin
            q.delete();
            for (int k = 0; k < 3004; k++) q.push_back(16'h0100 + 16'(k));
            q[r == 0 ? TB - 1 : 0] = HALT_A;
            predict(q, SA, TA, ea, ca);
            predict(q, SB, TB, eb, cb);
            start_run();
            for (int k = 0; k <= (ea > eb ? ea : eb) + 3; k++) begin
                step(q[k]);
                vectors += 2;
                if (obs_a !== exp_vec(ea, ca, k)) begin errors++; $display("FAIL prio%0d_a k=%0d got %h want %h", r, k, obs_a, exp_vec(ea, ca, k)); end
                if (obs_b !== exp_vec(eb, cb, k)) begin errors++; $display("FAIL prio%0d_b k=%0d got %h want %h", r, k, obs_b, exp_vec(eb, cb, k)); end
            end
        end
    endtask

    task automatic test_random();
        int ea, ca, eb, cb;
        for (int r = 0; r < 6; r++) begin
            int          rep;
            logic [15:0] v;
            rep = (r % 3 == 0) ? 50 : (r % 3 == 1) ? 90 : 97;
            v   = 16'($urandom_range(0, 31));
            q.delete();
            for (int k = 0; k < 3004; k++) begin
                if ($urandom_range(0, 99) >= rep) v = 16'($urandom_range(0, 31));
                q.push_back(v);
            end
            predict(q, SA, TA, ea, ca);
            predict(q, SB, TB, eb, cb);
            start_run();
            for (int k = 0; k <= (ea > eb ? ea : eb) + 3; k++) begin
                step(q[k]);
                vectors += 2;
                if (obs_a !== exp_vec(ea, ca, k)) begin errors++; $display("FAIL rand%0d_a k=%0d got %h want %h", r, k, obs_a, exp_vec(ea, ca, k)); end
                if (obs_b !== exp_vec(eb, cb, k)) begin errors++; $display("FAIL rand%0d_b k=%0d got %h want %h", r, k, obs_b, exp_vec(eb, cb, k)); end
            end
        end
    endtask

    task automatic test_trace();
        int          ea, ca, eb, cb;
        logic [23:0] exp;
        q.delete();
        for (int k = 1; k <= 10; k++) q.push_back(16'(k));
        for (int k = 0; k < 3000; k++) q.push_back(HALT_A);
        predict(q, SA, TA, ea, ca);
        predict(q, SB, TB, eb, cb);
        start_run();
        for (int k = 0; k <= ea + 3; k++) step(q[k]);
        for (int i = 0; i < 8; i++) begin
            trace_idx = 3'(i);
            #1;
`ifdef CPU6_BENCH_TRACE_EN
            exp = (ea - i >= 0) ? {q[ea - i], dq[ea - i]} : 24'h0;
`else
            exp = 24'h0;
`endif
            vectors += 2;
            if ({ta_a, td_a} !== exp) begin errors++; $display("FAIL trace_a idx=%0d got %h want %h", i, {ta_a, td_a}, exp); end
            if ({ta_b, td_b} !== exp) begin errors++; $display("FAIL trace_b idx=%0d got %h want %h", i, {ta_b, td_b}, exp); end
        end
        trace_idx = 3'd0;
        vectors++;
        if (obs_a !== exp_vec(ea, ca, ea)) begin errors++; $display("FAIL trace_end_a got %h want %h", obs_a, exp_vec(ea, ca, ea)); end
    endtask

    task automatic test_mid_reset();
        start_run();
        for (int k = 0; k < 5; k++) step(16'h0200 + 16'(k));
        reset = 1'b0;
        @(posedge clock); #1;
        vectors += 3;
        if (obs_a !== RESET_VEC) begin errors++; $display("FAIL midreset_a got %h want %h", obs_a, RESET_VEC); end
        if (obs_b !== RESET_VEC) begin errors++; $display("FAIL midreset_b got %h want %h", obs_b, RESET_VEC); end
        if ({ta_a, td_a} !== 24'h0) begin errors++; $display("FAIL midreset_trace got %h want %h", {ta_a, td_a}, 24'h0); end
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        address_bus = 16'h0;
        data_bus    = 8'h0;
        trace_idx   = 3'd0;
        test_reset();
        test_halt();
        test_stall();
        test_timeout();
        test_priority();
        test_random();
        test_trace();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
